systolic_array_nxm: RTL and testbench

//   Parametrised ROWS x COLS output-stationary systolic matmul engine computing C = A*B.

---
 rtl/tpu_pkg.sv | 28 ++
 rtl/pe_mac.sv | 53 +++++
 rtl/systolic_array_nxm.sv | 182 ++++++++++++++++++
 tb/tb_systolic_array_nxm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic matmul engines: default widths,
// the job state encoding and product extension.
package tpu_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ACC_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN
  } state_t;

  // Extend a pw-bit product to 64 bits, replicating its top bit when signed.
  function automatic logic [63:0] ext_product(input logic [63:0] p,
                                              input int unsigned pw,
                                              input logic sgn);
    logic [63:0] r;
    r = p;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= pw) r[i] = sgn & p[pw-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// One processing element: multiply-accumulate on the incoming operands and
// forward a to the right and b downward through one register each.
module pe_mac
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter bit          SIGNED     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [PW-1:0]         a_x;
  logic [PW-1:0]         b_x;
  logic [PW-1:0]         prod;
  logic [ACC_WIDTH-1:0]  prod_acc;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [ACC_WIDTH-1:0]  acc_q;

  // Low PW bits of the product of extended operands equal the true product.
  assign a_x      = {{DATA_WIDTH{SIGNED & a_i[DATA_WIDTH-1]}}, a_i};
  assign b_x      = {{DATA_WIDTH{SIGNED & b_i[DATA_WIDTH-1]}}, b_i};
  assign prod     = a_x * b_x;
  assign prod_acc = ACC_WIDTH'(ext_product(64'(prod), PW, SIGNED));

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_q + prod_acc;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_array_nxm.sv
// ROWS x COLS output-stationary systolic engine computing C = A*B from a
// column/row beat stream, draining C one row per handshake.
module systolic_array_nxm
  import tpu_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int unsigned K_MAX      = 16,
  parameter bit          SIGNED     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(K_MAX+1)-1:0]    k_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    a_in,
  input  logic [COLS*DATA_WIDTH-1:0]    b_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*ACC_WIDTH-1:0]     out_row,
  output logic [$clog2(ROWS)-1:0]       out_row_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned DW         = DATA_WIDTH;
  localparam int unsigned AW         = ACC_WIDTH;
  localparam int unsigned KW         = $clog2(K_MAX + 1);
  localparam int unsigned RIW        = $clog2(ROWS);
  localparam int unsigned FLUSH_LEN  = ROWS + COLS - 2;
  localparam int unsigned FW         = $clog2(ROWS + COLS);
  localparam logic [FW-1:0]  FLUSH_LAST = FW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);
  localparam logic [KW-1:0]  K_CAP      = KW'(K_MAX);
  localparam logic [RIW-1:0] ROW_LAST   = RIW'(ROWS - 1);

  state_t         state_q;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  beat_q;
  logic [FW-1:0]  flush_q;
  logic [RIW-1:0] row_q;
  logic           accept;
  logic           mac_en;
  logic           mac_clr;

  logic [DW-1:0] a_inj [ROWS];
  logic [DW-1:0] b_inj [COLS];
  logic [DW-1:0] a_h   [ROWS][COLS+1];
  logic [DW-1:0] b_v   [ROWS+1][COLS];
  logic [AW-1:0] acc   [ROWS][COLS];
  logic          unused_edge;

  assign in_ready    = (state_q == FEED);
  assign out_valid   = (state_q == DRAIN);
  assign busy        = (state_q != IDLE);
  assign accept      = in_valid & in_ready;
  assign mac_en      = (state_q == FEED) || (state_q == FLUSH);
  assign mac_clr     = (state_q == CLEAR);
  assign done        = out_valid & out_ready & (row_q == ROW_LAST);
  assign out_row_idx = row_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CLEAR;
            k_q     <= (k_len > K_CAP) ? K_CAP : k_len;
          end
        end
        CLEAR: begin
          beat_q  <= '0;
          flush_q <= '0;
          row_q   <= '0;
          state_q <= (k_q == '0) ? DRAIN : FEED;
        end
        FEED: begin
          if (accept) begin
            beat_q <= beat_q + KW'(1);
            if (beat_q == k_q - KW'(1)) state_q <= (FLUSH_LEN == 0) ? DRAIN : FLUSH;
          end
        end
        FLUSH: begin
          flush_q <= flush_q + FW'(1);
          if (flush_q == FLUSH_LAST) state_q <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (row_q == ROW_LAST) begin
              row_q   <= '0;
              state_q <= IDLE;
            end else begin
              row_q <= row_q + RIW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Non-accepted cycles feed zeros so bubbles and flush leave sums untouched.
  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) a_inj[r] = accept ? a_in[r*DW +: DW] : '0;
    for (int unsigned c = 0; c < COLS; c++) b_inj[c] = accept ? b_in[c*DW +: DW] : '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_h[r][0] = a_inj[r];
    end else begin : g_dly
      logic [DW-1:0] dly_q [r];
      always_ff @(posedge clk) begin
        if (!rst_n || mac_clr) begin
          for (int unsigned i = 0; i < r; i++) dly_q[i] <= '0;
        end else if (mac_en) begin
          dly_q[0] <= a_inj[r];
          for (int unsigned i = 1; i < r; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign a_h[r][0] = dly_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    if (c == 0) begin : g_direct
      assign b_v[0][c] = b_inj[c];
    end else begin : g_dly
      logic [DW-1:0] dly_q [c];
      always_ff @(posedge clk) begin
        if (!rst_n || mac_clr) begin
          for (int unsigned i = 0; i < c; i++) dly_q[i] <= '0;
        end else if (mac_en) begin
          dly_q[0] <= b_inj[c];
          for (int unsigned i = 1; i < c; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign b_v[0][c] = dly_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      pe_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (a_h[r][c]),
        .b_i   (b_v[r][c]),
        .a_o   (a_h[r][c+1]),
        .b_o   (b_v[r+1][c]),
        .acc_o (acc[r][c])
      );
    end
  end

  // Operands leaving the right and bottom edges have no consumer.
  always_comb begin
    unused_edge = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) unused_edge = unused_edge ^ (^a_h[r][COLS]);
    for (int unsigned c = 0; c < COLS; c++) unused_edge = unused_edge ^ (^b_v[ROWS][c]);
  end

  always_comb begin
    out_row = '0;
    for (int unsigned c = 0; c < COLS; c++) out_row[c*AW +: AW] = acc[row_q][c];
  end

endmodule

// File: tb/tb_systolic_array_nxm.sv
// Directed scoreboard bench for systolic_array_nxm (4x4, signed, 8/16 bit).
module tb_systolic_array_nxm;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int KM = 16;
  localparam int KW = $clog2(KM + 1);
  localparam bit SG = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              in_valid;
  logic              in_ready;
  logic [R*DW-1:0]   a_in;
  logic [C*DW-1:0]   b_in;
  logic              out_valid;
  logic              out_ready;
  logic [C*AW-1:0]   out_row;
  logic [$clog2(R)-1:0] out_row_idx;
  logic              busy;
  logic              done;

  systolic_array_nxm #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KM), .SIGNED(SG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int ready_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_ready) ready_cnt <= ready_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int last_acc_cyc = 0;
  int A [R][KM];
  int B [KM][C];
  logic [C*AW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v);
    int u;
    u = v & 255;
    if (SG && u >= 128) return u - 256;
    return u;
  endfunction

  task automatic push_expected(input int k);
    logic [C*AW-1:0] row;
    int s;
    for (int r = 0; r < R; r++) begin
      row = '0;
      for (int c = 0; c < C; c++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += sx(A[r][kk]) * sx(B[kk][c]);
        row[c*AW +: AW] = s[AW-1:0];
      end
      exp_q.push_back(row);
    end
  endtask

  task automatic set_identity();
    for (int k = 0; k < KM; k++) begin
      for (int r = 0; r < R; r++) A[r][k] = (r == k) ? 1 : 0;
      for (int c = 0; c < C; c++) B[k][c] = (k < 4) ? 4 * k + c + 1 : 0;
    end
  endtask

  // Issues start and offers beats until nbeats have been accepted.
  task automatic feed(input int klen, input bit bubbles, input int nbeats);
    int t, n;
    bit seen;
    t = 0; n = 0; seen = 0;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(klen);
    while (t < nbeats && n < 200) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (bubbles && (n % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int r = 0; r < R; r++) a_in[r*DW +: DW] = A[r][t][DW-1:0];
        for (int c = 0; c < C; c++) b_in[c*DW +: DW] = B[t][c][DW-1:0];
      end
      if (seen) chk("in_ready_feed", in_ready, 1);
      if (in_ready) seen = 1;
      if (in_valid && in_ready) begin
        t++;
        last_acc_cyc = cyc;
      end
    end
    if (n >= 200) chk("feed_timeout", t, nbeats);
  endtask

  task automatic drain(input int bp_row, input int bp_cycles, input bit hold_start,
                       input bit check_lat);
    int rows, n, stall;
    bit first, stalled;
    logic [C*AW-1:0] prev_row, exp_row;
    logic [$clog2(R)-1:0] prev_idx;
    rows = 0; n = 0; stall = 0; first = 1; stalled = 0;
    prev_row = '0; prev_idx = '0;
    while (rows < R && n < 300) begin
      @(negedge clk);
      n++;
      start    = hold_start;
      in_valid = 1'b1;
      a_in     = $urandom;
      b_in     = $urandom;
      out_ready = !(out_valid && int'(out_row_idx) == bp_row && stall < bp_cycles);
      if (!out_ready) stall++;
      #1;
      if (stalled) begin
        chk("bp_valid", out_valid, 1);
        chk("bp_row_stable", out_row, prev_row);
        chk("bp_idx_stable", out_row_idx, prev_idx);
      end
      if (out_valid) begin
        if (first) begin
          first = 0;
          if (check_lat) chk("latency", cyc - last_acc_cyc, R + C - 1);
        end
        if (out_ready) begin
          exp_row = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          chk("row_data", out_row, exp_row);
          chk("row_idx", out_row_idx, rows);
          chk("done", done, (rows == R - 1));
          rows++;
          stalled = 0;
        end else begin
          chk("done_stall", done, 0);
          prev_row = out_row;
          prev_idx = out_row_idx;
          stalled = 1;
        end
      end
    end
    if (n >= 300) chk("drain_timeout", rows, R);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_idx", out_row_idx, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_row"}, out_row, 0);
    chk({tag, "_idx"}, out_row_idx, 0);
  endtask

  int snap;

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
    out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Identity
    set_identity();
    push_expected(4);
    feed(4, 1'b0, 4);
    drain(99, 0, 1'b0, 1'b1);

    // Bubbles on alternate cycles
    push_expected(4);
    feed(4, 1'b1, 4);
    drain(99, 0, 1'b0, 1'b1);

    // Backpressure on row 1
    push_expected(4);
    feed(4, 1'b0, 4);
    drain(1, 3, 1'b0, 1'b1);

    // Signed wrap: -128 * 127 summed four times
    for (int k = 0; k < KM; k++) begin
      for (int r = 0; r < R; r++) A[r][k] = 8'h80;
      for (int c = 0; c < C; c++) B[k][c] = 8'h7F;
    end
    push_expected(4);
    feed(4, 1'b0, 4);
    drain(99, 0, 1'b0, 1'b1);

    // Random data, k_len above K_MAX clamps to K_MAX
    for (int k = 0; k < KM; k++) begin
      for (int r = 0; r < R; r++) A[r][k] = $urandom_range(0, 255);
      for (int c = 0; c < C; c++) B[k][c] = $urandom_range(0, 255);
    end
    push_expected(KM);
    feed(KM + 4, 1'b1, KM);
    drain(2, 2, 1'b0, 1'b1);

    // Empty job
    snap = ready_cnt;
    push_expected(0);
    feed(0, 1'b0, 0);
    drain(99, 0, 1'b0, 1'b0);
    chk("empty_no_ready", ready_cnt - snap, 0);

    // Reset mid-FEED after two beats, then a clean identity job
    set_identity();
    feed(4, 1'b0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check_reset_values("midreset");
    rst_n = 1'b1;
    push_expected(4);
    feed(4, 1'b0, 4);
    drain(99, 0, 1'b1, 1'b1);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
